reg_dump_uart_tx: RTL and testbench
===================================

Name: reg_dump_uart_tx

Overview:
- Debug read-side consumer of the register file's debug read port.
- On a start request it walks register indices 0..NUM_REGS-1. For each index it drives the select, captures the returned word, and serialises it over a UART 8N1 transmit line.
- Sits between the CPU register file debug port and the board UART TX pin. It gives a host a full architectural register dump without halting the datapath.

Parameters:
- WIDTH, 32, register word width; must be a multiple of 8.
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1, max 32).
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  dump request, sampled only in IDLE.
- dbg_data  input  WIDTH  word returned by register file debug port for dbg_sel.
- dbg_sel  output  5  register index driven to debug port select.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from cycle after accepted start until dump complete.
- done  output  1  single-cycle pulse when last stop bit of last register finishes.

Behaviour:
- Reset (async, immediate): tx=1, busy=0, done=0, dbg_sel=0, FSM=IDLE, all counters 0. Reset mid-frame forces tx high at once; a partial frame is abandoned, with no resumption.
- FSM states: IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE:
  - tx=1, busy=0.
  - start=1 at edge N moves to LOAD. busy=1 and dbg_sel=0 are visible from N+1.
  - start while busy is ignored; there is no queuing.
- LOAD:
  - dbg_sel has been stable for ≥1 cycle. Latch dbg_data into the word buffer.
  - byte_idx=WIDTH/8-1, so the MSB byte is sent first (big-endian on the wire).
  - Go to START_BIT.
  - LOAD lasts exactly 1 cycle, so the first tx falling edge occurs at N+2.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, then DATA_BITS with bit_idx=0.
- DATA_BITS:
  - tx = current byte bit[bit_idx], LSB first, each bit CLKS_PER_BIT cycles.
  - After bit 7, go to STOP_BIT.
- STOP_BIT:
  - tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx>0: decrement it, go to START_BIT. There is no idle gap between bytes.
  - Else go to NEXT.
- NEXT:
  - If dbg_sel==NUM_REGS-1: go to IDLE, busy=0, done=1 for that one cycle.
  - Else dbg_sel+=1 and go to LOAD.
  - NEXT is 1 cycle with tx=1, so there is a 2-cycle idle-high gap between registers (NEXT+LOAD).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets on every state entry; no drift accumulates.
  - Width is clog2(CLKS_PER_BIT).
- Frame: 10 bits. Per register: WIDTH/8 frames.
- Dump duration, start sample to done pulse:
  - NUM_REGS*(WIDTH/8)*10*CLKS_PER_BIT + 2*NUM_REGS cycles.
  - With NUM_REGS=32, WIDTH=32: 1280*CLKS_PER_BIT+64 cycles.
- Consistency:
  - Each register is sampled exactly once, in its LOAD cycle.
  - There is no atomic snapshot across registers. Writes to a register after its LOAD are not reflected.
  - Index 0 transmits all zero bytes.
- dbg_sel upper bits are unused when NUM_REGS<32. dbg_sel never exceeds NUM_REGS-1.
- start held high continuously: a new dump begins in the cycle after done, i.e. the IDLE cycle.

Test Plan:
- Reset with tx observed; assert reset mid-DATA_BITS (CLKS_PER_BIT=4) -> tx=1, busy=0, dbg_sel=0 in the same cycle, without waiting for an edge. Next start gives a clean frame from index 0.
- CLKS_PER_BIT=4, NUM_REGS=2, reg0=0, reg1=0xDEADBEEF, pulse start -> bytes decoded in order 00 00 00 00 DE AD BE EF. Each bit is 4 cycles. done pulses exactly 2*4*10*4+4=324 cycles after the start sample.
- Frame timing with CLKS_PER_BIT=4, byte 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. No gap between bytes of one register; 2 idle-high cycles between registers.
- start pulsed again while busy (mid reg1) -> ignored: dump completes once, single done pulse, dbg_sel never repeats.
- reg1 changes from 0x11111111 to 0x22222222 one cycle after its LOAD -> transmitted 11 11 11 11. A change one cycle before LOAD -> transmits 22 22 22 22.
- NUM_REGS=32 default, registers loaded with index value i -> 128 bytes received, register k sent as 00 00 00 k. busy low and tx high after done.

Source files
------------

// File: rtl/reg_dump_uart_tx.sv
// Walks debug-port register indices 0..NUM_REGS-1 and sends each word MSB byte first over UART 8N1.
// Dump takes NUM_REGS*(WIDTH/8*10*CLKS_PER_BIT + 2) cycles; no backpressure, start is ignored while busy.
module reg_dump_uart_tx #(
    parameter int WIDTH        = 32,
    parameter int NUM_REGS     = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dbg_data,
    output logic [4:0]       dbg_sel,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int NBYTES = WIDTH / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    SEL_LAST   = 5'(NUM_REGS - 1);
    localparam logic [BW-1:0] BYTE_FIRST = BW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [BW-1:0]    byte_idx_q;
    logic [2:0]       bit_idx_q;
    logic [6:0]       shift_q;
    logic [CW-1:0]    baud_q;
    logic [4:0]       sel_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic [7:0]       cur_byte;
    logic             baud_end;

    assign cur_byte = 8'(word_q >> {byte_idx_q, 3'b000});
    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            baud_q     <= '0;
            sel_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        sel_q   <= '0;
                        baud_q  <= '0;
                    end
                end

                // dbg_sel was updated on entry, so dbg_data has settled by this edge
                LOAD: begin
                    word_q     <= dbg_data;
                    byte_idx_q <= BYTE_FIRST;
                    tx_q       <= 1'b0;
                    baud_q     <= '0;
                    state_q    <= START_BIT;
                end

                START_BIT: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= cur_byte[0];
                        shift_q   <= cur_byte[7:1];
                        state_q   <= DATA_BITS;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end

                DATA_BITS: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP_BIT;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[6:1]};
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end

                // Back-to-back frames within a word; done/busy settle on entry to the final NEXT
                STOP_BIT: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (byte_idx_q != '0) begin
                            byte_idx_q <= byte_idx_q - BW'(1);
                            tx_q       <= 1'b0;
                            state_q    <= START_BIT;
                        end else begin
                            state_q <= NEXT;
                            if (sel_q == SEL_LAST) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end

                NEXT: begin
                    baud_q <= '0;
                    if (sel_q == SEL_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        sel_q   <= sel_q + 5'd1;
                        state_q <= LOAD;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_sel = sel_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx: a 2-register and a 32-register instance, both at 4 clocks per bit.
module tb_reg_dump_uart_tx;

    localparam int CPB     = 4;
    localparam int REG_CYC = 4 * 10 * CPB + 2;

    typedef struct {
        logic [31:0] reg1;
        int          restart_at;
        int          chg_at;
        logic [31:0] chg_val;
        logic [31:0] exp1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [31:0] regs_a [0:31];
    logic [31:0] regs_b [0:31];
    logic [31:0] dbg_data_a, dbg_data_b;
    logic [4:0]  dbg_sel_a, dbg_sel_b;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    int   checks = 0;
    int   errors = 0;
    logic cap      [0:5199];
    logic busy_cap [0:5199];
    int   done_at, done_cnt;
    bit   sel_ok;

    assign dbg_data_a = regs_a[dbg_sel_a];
    assign dbg_data_b = regs_b[dbg_sel_b];

    reg_dump_uart_tx #(.WIDTH(32), .NUM_REGS(2), .CLKS_PER_BIT(CPB)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start_a),
        .dbg_data (dbg_data_a),
        .dbg_sel  (dbg_sel_a),
        .tx       (tx_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    reg_dump_uart_tx #(.WIDTH(32), .NUM_REGS(32), .CLKS_PER_BIT(CPB)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start_b),
        .dbg_data (dbg_data_b),
        .dbg_sel  (dbg_sel_b),
        .tx       (tx_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {frame_ok, byte} for the frame whose start bit begins at capture index base
    function automatic logic [8:0] decode(input int base);
        logic [7:0] b;
        logic       ok;
        ok = 1'b1;
        b  = '0;
        for (int c = 0; c < CPB; c++) begin
            if (cap[base + c] !== 1'b0) ok = 1'b0;
            if (cap[base + 9 * CPB + c] !== 1'b1) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            b[i] = cap[base + CPB * (i + 1)];
            for (int c = 1; c < CPB; c++)
                if (cap[base + CPB * (i + 1) + c] !== b[i]) ok = 1'b0;
        end
        return {ok, b};
    endfunction

    task automatic run_dump(input bit use_b, input int ncyc, input int restart_at,
                            input int chg_at, input logic [31:0] chg_val, input int max_sel);
        int         prev_sel;
        logic [4:0] s;
        logic       d;
        done_at  = -1;
        done_cnt = 0;
        sel_ok   = 1'b1;
        prev_sel = 0;
        @(negedge clk);
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start_a = (!use_b && k == restart_at);
            start_b = 1'b0;
            if (k == chg_at) regs_a[1] = chg_val;
            cap[k]      = use_b ? tx_b   : tx_a;
            busy_cap[k] = use_b ? busy_b : busy_a;
            d           = use_b ? done_b : done_a;
            s           = use_b ? dbg_sel_b : dbg_sel_a;
            if (d) begin
                done_cnt++;
                done_at = k;
            end
            if (int'(s) < prev_sel || int'(s) > max_sel) sel_ok = 1'b0;
            prev_sel = int'(s);
        end
    endtask

    task automatic check_dump(input string tag, input int nregs, input logic [31:0] exp1, input bit b_mode);
        int          total;
        logic [31:0] word, exp;
        logic [8:0]  d;
        bit          gap_ok, frm_ok;
        total  = nregs * REG_CYC;
        gap_ok = 1'b1;
        frm_ok = 1'b1;
        chk($sformatf("%s/done_at", tag), 32'(done_at), 32'(total));
        chk($sformatf("%s/done_cnt", tag), 32'(done_cnt), 32'd1);
        chk($sformatf("%s/busy_first", tag), 32'(busy_cap[1]), 32'd1);
        chk($sformatf("%s/busy_after", tag), 32'(busy_cap[total + 1]), 32'd0);
        chk($sformatf("%s/tx_idle_after", tag), 32'(cap[total + 1] & cap[total + 6]), 32'd1);
        chk($sformatf("%s/sel_seq", tag), 32'(sel_ok), 32'd1);
        for (int r = 0; r < nregs; r++) begin
            if (cap[r * REG_CYC + 1] !== 1'b1 || cap[r * REG_CYC + REG_CYC] !== 1'b1) gap_ok = 1'b0;
            word = '0;
            for (int j = 0; j < 4; j++) begin
                d = decode(r * REG_CYC + 2 + j * 10 * CPB);
                if (!d[8]) frm_ok = 1'b0;
                word = {word[23:0], d[7:0]};
            end
            if (b_mode)      exp = 32'(r);
            else if (r == 0) exp = 32'h0;
            else             exp = exp1;
            chk($sformatf("%s/reg%0d", tag, r), word, exp);
        end
        chk($sformatf("%s/reg_gaps", tag), 32'(gap_ok), 32'd1);
        chk($sformatf("%s/frames", tag), 32'(frm_ok), 32'd1);
    endtask

    initial begin
        vec_t       vecs [5];
        logic [9:0] a5_seq;
        bit         ok;
        int         dk;

        vecs[0] = '{32'hDEADBEEF, 0,   0,   32'h0,        32'hDEADBEEF};
        vecs[1] = '{32'hA5A5A5A5, 0,   0,   32'h0,        32'hA5A5A5A5};
        vecs[2] = '{32'h00FF0180, 200, 0,   32'h0,        32'h00FF0180};
        vecs[3] = '{32'h11111111, 0,   164, 32'h22222222, 32'h11111111};
        vecs[4] = '{32'h11111111, 0,   162, 32'h22222222, 32'h22222222};
        a5_seq  = 10'b0101001011;

        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regs_a[i] = 32'h0;
            regs_b[i] = 32'(i);
        end
        #1;
        chk("reset/tx_a", 32'(tx_a), 32'd1);
        chk("reset/busy_a", 32'(busy_a), 32'd0);
        chk("reset/sel_a", 32'(dbg_sel_a), 32'd0);
        chk("reset/done_a", 32'(done_a), 32'd0);
        chk("reset/tx_b", 32'(tx_b), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            regs_a[1] = vecs[i].reg1;
            run_dump(1'b0, REG_CYC * 2 + 6, vecs[i].restart_at, vecs[i].chg_at, vecs[i].chg_val, 1);
            check_dump($sformatf("vec%0d", i), 2, vecs[i].exp1, 1'b0);
            if (vecs[i].reg1 == 32'hA5A5A5A5) begin
                ok = 1'b1;
                for (int t = 0; t < 10; t++)
                    for (int c = 0; c < CPB; c++)
                        if (cap[REG_CYC + 2 + CPB * t + c] !== a5_seq[9 - t]) ok = 1'b0;
                chk("a5_frame", 32'(ok), 32'd1);
            end
            repeat (3) @(negedge clk);
        end

        // start held high: next dump starts from the IDLE cycle after done
        regs_a[1] = 32'h0;
        dk = -1;
        start_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 340; k++) begin
            @(negedge clk);
            busy_cap[k] = busy_a;
            if (done_a && dk < 0) dk = k;
        end
        start_a = 1'b0;
        chk("held/done_at", 32'(dk), 32'd324);
        chk("held/busy_idle", 32'(busy_cap[325]), 32'd0);
        chk("held/busy_restart", 32'(busy_cap[326]), 32'd1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // asynchronous reset in the middle of register 1's first data bit
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (170) @(negedge clk);
        chk("midreset/pre_tx", 32'(tx_a), 32'd0);
        chk("midreset/pre_sel", 32'(dbg_sel_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset/tx", 32'(tx_a), 32'd1);
        chk("midreset/busy", 32'(busy_a), 32'd0);
        chk("midreset/sel", 32'(dbg_sel_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        regs_a[1] = 32'hDEADBEEF;
        run_dump(1'b0, REG_CYC * 2 + 6, 0, 0, 32'h0, 1);
        check_dump("post_reset", 2, 32'hDEADBEEF, 1'b0);

        run_dump(1'b1, REG_CYC * 32 + 6, 0, 0, 32'h0, 31);
        check_dump("full32", 32, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
